pool_stream_tx: RTL

- Transmit side of the pooling stream interface: accepts one group of GROUP pixels in parallel through a valid/ready handshake.
- Serialises the group onto an 8-bit pixel stream, one pixel per clk, in the exact form the pooling receiver expects.
- Drives the receiver's capture strobe during the last pixel of each group, so the receiver latches all GROUP pixels at once.
- Sits between the convolution result buffer and the pooling stage, and supports gap-free back-to-back groups.

---
 rtl/pool_stream_tx.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pool_stream_tx.sv
// Pooling-stream transmitter: takes GROUP pixels per handshake and streams them
// one per clk to the pooling receiver, strobing its capture enable on the last pixel.

module pool_stream_tx_lane #(
  parameter int PIXEL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               act_ld,
  input  logic               act_sh,
  input  logic               pend_we,
  input  logic [PIXEL_W-1:0] ld_d,
  input  logic [PIXEL_W-1:0] sh_d,
  input  logic [PIXEL_W-1:0] pend_d,
  output logic [PIXEL_W-1:0] act_q,
  output logic [PIXEL_W-1:0] pend_q
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_q  <= '0;
      pend_q <= '0;
    end else begin
      if (act_ld)      act_q <= ld_d;
      else if (act_sh) act_q <= sh_d;
      if (pend_we)     pend_q <= pend_d;
    end
  end
endmodule

module pool_stream_tx #(
  parameter int PIXEL_W = 8,
  parameter int GROUP   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [GROUP*PIXEL_W-1:0] in_pixels,
  output logic [PIXEL_W-1:0]       out_pixel,
  output logic                     out_en,
  output logic                     busy,
  output logic [CNT_W-1:0]         group_count
);
  localparam int IDX_W = $clog2(GROUP);
  localparam logic [IDX_W-1:0] LAST     = IDX_W'(GROUP - 1);
  localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(GROUP - 2);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                          state;
  logic [IDX_W-1:0]                idx;
  logic                            pend_vld;
  logic                            accept, last, from_pend;
  logic                            act_ld, act_sh, pend_we;
  logic [GROUP-1:0][PIXEL_W-1:0]   pix_in, src, act_q, pend_q, ld_d, sh_d;

  assign pix_in    = in_pixels;
  assign in_ready  = !pend_vld;
  assign accept    = in_valid && in_ready;
  assign last      = (state == SEND) && (idx == LAST);
  assign from_pend = last && pend_vld;
  assign src       = from_pend ? pend_q : pix_in;
  assign busy      = (state == SEND) || pend_vld;

  // Pixel 0 goes straight to out_pixel on load, so the active buffer holds
  // pixels 1..GROUP-1 pre-shifted and every later cycle just pops lane 0.
  assign act_ld  = ((state == IDLE) && accept) || (last && (pend_vld || accept));
  assign act_sh  = (state == SEND) && !last;
  assign pend_we = accept && (state == SEND) && (!last || pend_vld);

  for (genvar k = 0; k < GROUP; k++) begin : g_lane
    if (k == GROUP - 1) begin : g_top
      assign ld_d[k] = '0;
      assign sh_d[k] = '0;
    end else begin : g_mid
      assign ld_d[k] = src[k+1];
      assign sh_d[k] = act_q[k+1];
    end

    pool_stream_tx_lane #(.PIXEL_W(PIXEL_W)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .act_ld (act_ld),
      .act_sh (act_sh),
      .pend_we(pend_we),
      .ld_d   (ld_d[k]),
      .sh_d   (sh_d[k]),
      .pend_d (pix_in[k]),
      .act_q  (act_q[k]),
      .pend_q (pend_q[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      pend_vld    <= 1'b0;
      out_pixel   <= '0;
      out_en      <= 1'b0;
      group_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= SEND;
            idx       <= '0;
            out_pixel <= src[0];
            out_en    <= 1'b0;
          end
        end
        SEND: begin
          if (!last) begin
            idx       <= idx + 1'b1;
            out_pixel <= act_q[0];
            out_en    <= (idx == PRE_LAST);
            if (accept) pend_vld <= 1'b1;
          end else begin
            group_count <= group_count + 1'b1;
            out_en      <= 1'b0;
            idx         <= '0;
            // pending (or a same-edge accept) continues with no gap
            if (pend_vld || accept) begin
              out_pixel <= src[0];
              pend_vld  <= 1'b0;
            end else begin
              state     <= IDLE;
              out_pixel <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
